// File: rtl/exe_flag_stage.sv
// EXE/MEM pipeline register with the architectural {Z,C,N,V} status register
// and the condition-code evaluator for the instruction sitting in ID.
module exe_flag_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              s_bit,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_status,
  input  logic [REG_AW-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] store_val,
  input  logic [3:0]        cond,
  output logic [3:0]        status_q,
  output logic              c_flag,
  output logic              cond_pass,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_store_val
);

  logic       flag_we;
  logic [3:0] flags;
  logic       z, c, n, v;

  assign flag_we = in_valid & s_bit & ~freeze & ~flush;
  assign flags   = (BYPASS && flag_we) ? alu_status : status_q;
  assign {z, c, n, v} = flags;

  // ADC/SBC must always see the committed carry, never the bypassed one
  assign c_flag = status_q[2];

  // Status register: written only by a live, unstalled, unsquashed S-op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else if (flag_we) begin
      status_q <= alu_status;
    end
  end

  // EXE/MEM register: flush zeroes it, freeze holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_alu       <= '0;
      out_dest      <= '0;
      out_wb_en     <= 1'b0;
      out_mem_r_en  <= 1'b0;
      out_mem_w_en  <= 1'b0;
      out_store_val <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_alu       <= '0;
      out_dest      <= '0;
      out_wb_en     <= 1'b0;
      out_mem_r_en  <= 1'b0;
      out_mem_w_en  <= 1'b0;
      out_store_val <= '0;
    end else if (!freeze) begin
      out_valid     <= in_valid;
      out_alu       <= alu_out;
      out_dest      <= dest;
      out_wb_en     <= wb_en & in_valid;
      out_mem_r_en  <= mem_r_en & in_valid;
      out_mem_w_en  <= mem_w_en & in_valid;
      out_store_val <= store_val;
    end
  end

  // Condition decode for the ID-stage instruction
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
    endcase
  end

endmodule
